// File: rtl/split_ctrl_if.sv
// Handshake bundle between split_ctrl, the split slave core and the bus arbiter.
// The controller takes the slave modport; the driving side takes the master modport.
interface split_ctrl_if;
    logic req_valid;
    logic slv_done;
    logic split_grant;
    logic slv_start;
    logic ssplit;
    logic sreadysp;
    logic rsp_valid;
    logic timeout_err;
    logic busy;

    modport slave (
        input  req_valid, slv_done, split_grant,
        output slv_start, ssplit, sreadysp, rsp_valid, timeout_err, busy
    );

    modport master (
        output req_valid, slv_done, split_grant,
        input  slv_start, ssplit, sreadysp, rsp_valid, timeout_err, busy
    );
endinterface

// File: rtl/split_ctrl.sv
// Split-transaction controller: launches the slave core, raises ssplit when the core is slow,
// then sequences the resume handshake. Define SPLIT_CTRL_TIMEOUT_EN to enable the split watchdog.
module split_ctrl #(
    parameter int SPLIT_THRESH = 4,
    parameter int TIMEOUT      = 200,
    parameter int CNT_W        = 8
) (
    input  logic         clk,
    input  logic         rst,
    split_ctrl_if.slave  bus
);
    if (SPLIT_THRESH < 1 || SPLIT_THRESH > (1 << CNT_W) - 1) begin : g_bad_thresh
        $error("split_ctrl: SPLIT_THRESH out of range");
    end
    if (TIMEOUT < 1 || TIMEOUT > (1 << CNT_W) - 1) begin : g_bad_timeout
        $error("split_ctrl: TIMEOUT out of range");
    end

    typedef enum logic [2:0] {IDLE, WAIT, SPLIT, RESUME, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR_M1  = CNT_W'(SPLIT_THRESH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             slv_start_q, slv_start_d;
    logic             ssplit_q, ssplit_d;
    logic             sreadysp_q, sreadysp_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;
    logic             wd_abort;

`ifdef SPLIT_CTRL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);
    logic timeout_err_q;
    // Fires on the edge where the counter would reach TIMEOUT; beats done/grant in that cycle.
    assign wd_abort        = (state_q == SPLIT || state_q == RESUME) && (cnt_q == TO_M1);
    assign bus.timeout_err = timeout_err_q;
`else
    assign wd_abort        = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_comb begin
        cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        state_d     = state_q;
        cnt_d       = cnt_q;
        slv_start_d = 1'b0;
        ssplit_d    = ssplit_q;
        sreadysp_d  = sreadysp_q;
        rsp_valid_d = 1'b0;
        if (wd_abort) begin
            state_d    = IDLE;
            ssplit_d   = 1'b0;
            sreadysp_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    sreadysp_d = 1'b1;
                    if (bus.req_valid) begin
                        state_d     = WAIT;
                        cnt_d       = '0;
                        slv_start_d = 1'b1;
                        sreadysp_d  = 1'b0;
                    end
                end
                WAIT: begin
                    cnt_d = cnt_inc;
                    if (bus.slv_done) begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                    end else if (cnt_q == THR_M1) begin
                        state_d  = SPLIT;
                        ssplit_d = 1'b1;
                        cnt_d    = '0;
                    end
                end
                SPLIT: begin
                    cnt_d = cnt_inc;
                    if (bus.slv_done) begin
                        state_d    = RESUME;
                        ssplit_d   = 1'b0;
                        sreadysp_d = 1'b1;
                    end
                end
                RESUME: begin
                    cnt_d = cnt_inc;
                    if (bus.split_grant) begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                    end
                end
                DONE: begin
                    state_d    = IDLE;
                    sreadysp_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            slv_start_q   <= 1'b0;
            ssplit_q      <= 1'b0;
            sreadysp_q    <= 1'b1;
            rsp_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
`ifdef SPLIT_CTRL_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            slv_start_q   <= slv_start_d;
            ssplit_q      <= ssplit_d;
            sreadysp_q    <= sreadysp_d;
            rsp_valid_q   <= rsp_valid_d;
            busy_q        <= busy_d;
`ifdef SPLIT_CTRL_TIMEOUT_EN
            timeout_err_q <= wd_abort;
`endif
        end
    end

    assign bus.slv_start = slv_start_q;
    assign bus.ssplit    = ssplit_q;
    assign bus.sreadysp  = sreadysp_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.busy      = busy_q;
endmodule

// File: doc/split_ctrl.md
# split_ctrl

Split-transaction controller for the bus's split-capable slave. It sits between the slave core and the bus arbiter. It launches each accepted request into the slave core and times the core's response. If the core is too slow, it asserts `ssplit` so the arbiter can release the bus, then sequences the resume handshake (`split_grant`) before delivering the response.

## Interface
- `SPLIT_THRESH`, default 4: WAIT cycles allowed before a split is raised; legal range 1..2^CNT_W-1.
- `TIMEOUT`, default 200: cycles allowed in SPLIT plus RESUME before abort; legal range 1..2^CNT_W-1.
- `CNT_W`, default 8: width of the shared cycle counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: one-cycle pulse; a transaction addressed to the split slave.
- `slv_done` in 1: one-cycle pulse from the slave core; the operation is complete.
- `split_grant` in 1: one-cycle pulse from the arbiter; the split owner is back on the bus.
- `slv_start` out 1: one-cycle pulse launching the slave core.
- `ssplit` out 1: split request to the arbiter.
- `sreadysp` out 1: split slave ready; feeds the arbiter's `sready` AND.
- `rsp_valid` out 1: one-cycle pulse; the response is ready for the bus master.
- `timeout_err` out 1: one-cycle pulse; the split was aborted.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- States: IDLE, WAIT, SPLIT, RESUME, DONE. All outputs are registered.
- Reset values: state IDLE, counter 0, `sreadysp`=1, every other output 0.
- IDLE:
  - `sreadysp`=1.
  - `req_valid` → WAIT, counter cleared to 0, `slv_start` pulsed, `sreadysp`←0.
- WAIT: counter increments each cycle.
  - `slv_done` → DONE.
  - Otherwise, when counter == SPLIT_THRESH-1 → SPLIT, `ssplit`←1, counter←0.
  - If `slv_done` arrives in the same cycle as the threshold, done wins and no split is raised.
- SPLIT: `ssplit`=1, `sreadysp`=0, counter increments.
  - `slv_done` → RESUME, `ssplit`←0, `sreadysp`←1.
- RESUME: `ssplit`=0, `sreadysp`=1, counter keeps incrementing.
  - `split_grant` → DONE.
- DONE: `rsp_valid`=1 for exactly one cycle, then → IDLE.
- `split_grant` outside RESUME is ignored. `slv_done` outside WAIT and SPLIT is ignored.
- `req_valid` while `busy`=1 is dropped. No queuing; one transaction is outstanding at most.
- Counter saturates at 2^CNT_W-1 and never wraps.
- Asserting `rst` in any state forces reset values immediately (asynchronously). An in-flight transaction is discarded and no `rsp_valid` is produced.

## Timing
- `req_valid` sampled high at edge T: `slv_start`=1 and `sreadysp`=0 during cycle T+1.
- `slv_done` sampled in WAIT at edge D: `rsp_valid`=1 during cycle D+1 (DONE).
- No `slv_done`: `ssplit` rises SPLIT_THRESH+1 cycles after `req_valid` was sampled.
- `slv_done` sampled in SPLIT at edge D: `ssplit`=0 and `sreadysp`=1 from D+1.
- `split_grant` sampled in RESUME at edge G: `rsp_valid`=1 during cycle G+1.
- Minimum request-to-response: 2 cycles (`slv_done` in the first WAIT cycle).
- `ssplit` is never high in the same cycle as `rsp_valid` or `sreadysp`.

## Configuration
- Macro `SPLIT_CTRL_TIMEOUT_EN`.
- Defined: if the counter reaches TIMEOUT in SPLIT or RESUME, the block goes to IDLE. `timeout_err` pulses for one cycle, `ssplit`←0, `sreadysp`←1, and no `rsp_valid` is produced. Timeout takes priority over a simultaneous `slv_done` or `split_grant`.
- Undefined: there is no watchdog. `timeout_err` is tied to 0, and SPLIT and RESUME wait indefinitely.

## Test plan
- Fast path, SPLIT_THRESH=4:
  - `req_valid` at cycle 0, `slv_done` at cycle 2.
  - Expect `slv_start` at cycle 1, `rsp_valid` at cycle 3, `ssplit` never high.
- Split path:
  - `req_valid` at 0, no `slv_done`. Expect `ssplit` rising at cycle 5.
  - Then `slv_done` at 10: expect `ssplit` 0 and `sreadysp` 1 at 11.
  - Then `split_grant` at 14: expect `rsp_valid` at 15.
- Race: `slv_done` coincident with counter == 3 in WAIT → DONE, `ssplit` stays 0.
- Timeout with `SPLIT_CTRL_TIMEOUT_EN`, TIMEOUT=10:
  - Split raised, no `slv_done`.
  - Expect `timeout_err` pulse 10 cycles after `ssplit` rose, then `busy`=0 and no `rsp_valid`.
- Reset mid-split: assert `rst` asynchronously while `ssplit`=1 → all outputs return to reset values before the next edge; a later `split_grant` has no effect.
- Dropped request: second `req_valid` during SPLIT → no second `slv_start`, exactly one `rsp_valid` for the first request.
